// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and select-width helpers for the register file
package rf_pkg;

    localparam int RF_MAX_DEPTH = 64;
    localparam int RF_MAX_NREAD = 4;

    function automatic int rf_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A select is never narrower than one bit, even for a two-entry file.
    function automatic int rf_aw(input int depth);
        return (rf_clog2(depth) < 1) ? 1 : rf_clog2(depth);
    endfunction

endpackage

// File: rtl/rf_reg.sv
// rtl/rf_reg.sv - single register with write enable and async active-low clear
module rf_reg
    import rf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rf_param.sv
// rtl/rf_param.sv - parametrised flop register file with bypass, zero register and sticky select error
module rf_param
    import rf_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 8,
    parameter  int NREAD    = 2,
    parameter  int ZERO_REG = 0,
    parameter  int BYPASS   = 1,
    localparam int AW       = rf_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    readregsel,
    output logic [NREAD*WIDTH-1:0] readdata,
    input  logic                   write,
    input  logic [AW-1:0]          writeregsel,
    input  logic [WIDTH-1:0]       writedata,
    output logic                   err
);

    if (DEPTH < 2 || DEPTH > RF_MAX_DEPTH || NREAD < 1 || NREAD > RF_MAX_NREAD) begin : g_bad_cfg
        $fatal(1, "rf_param: DEPTH or NREAD outside supported range");
    end

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_in_range;
    logic [NREAD-1:0] rd_oob;
    logic             err_event;

    assign wr_in_range = int'(writeregsel) < DEPTH;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_ff
            logic we;
            assign we = write && (int'(writeregsel) == i);
            rf_reg #(.WIDTH(WIDTH)) u_reg (
                .clk (clk),
                .rst (rst),
                .we  (we),
                .d   (writedata),
                .q   (regs[i])
            );
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]    sel;
        logic [WIDTH-1:0] rd;

        assign sel       = readregsel[k*AW +: AW];
        assign rd_oob[k] = int'(sel) >= DEPTH;

        // Range check comes first so the array is never indexed past DEPTH-1.
        always_comb begin
            rd = '0;
            if (rd_oob[k]) begin
                rd = '0;
            end else if (ZERO_REG != 0 && sel == '0) begin
                rd = '0;
            end else if (BYPASS != 0 && write && writeregsel == sel) begin
                rd = writedata;
            end else begin
                rd = regs[sel];
            end
        end

        assign readdata[k*WIDTH +: WIDTH] = rd;
    end

    // X/Z selects only exist in simulation; in hardware this term is constant 0.
    assign err_event = (write && !wr_in_range) || (|rd_oob)
                     || $isunknown(readregsel) || $isunknown(writeregsel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (err_event) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_param.sv
// tb/tb_rf_param.sv - self-checking bench for rf_param across several configurations
module tb_rf_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // shared stimulus for three 16x8 two-port instances: default, no bypass, zero register
    logic        w;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic [5:0]  rs;
    logic [31:0] d_rd, n_rd, z_rd;
    logic        d_err, n_err, z_err;

    // DEPTH=6 instance
    logic        s_w;
    logic [2:0]  s_ws;
    logic [15:0] s_wd;
    logic [5:0]  s_rs;
    logic [31:0] s_rd;
    logic        s_err;

    // WIDTH=32, NREAD=4 instance
    logic         q_w;
    logic [2:0]   q_ws;
    logic [31:0]  q_wd;
    logic [11:0]  q_rs;
    logic [127:0] q_rd;
    logic         q_err;

    rf_param u_def (
        .clk(clk), .rst(rst), .readregsel(rs), .readdata(d_rd),
        .write(w), .writeregsel(ws), .writedata(wd), .err(d_err)
    );
    rf_param #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .readregsel(rs), .readdata(n_rd),
        .write(w), .writeregsel(ws), .writedata(wd), .err(n_err)
    );
    rf_param #(.ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .readregsel(rs), .readdata(z_rd),
        .write(w), .writeregsel(ws), .writedata(wd), .err(z_err)
    );
    rf_param #(.DEPTH(6)) u_d6 (
        .clk(clk), .rst(rst), .readregsel(s_rs), .readdata(s_rd),
        .write(s_w), .writeregsel(s_ws), .writedata(s_wd), .err(s_err)
    );
    rf_param #(.WIDTH(32), .NREAD(4)) u_w32 (
        .clk(clk), .rst(rst), .readregsel(q_rs), .readdata(q_rd),
        .write(q_w), .writeregsel(q_ws), .writedata(q_wd), .err(q_err)
    );

    // reference contents: mdl[0]=default, mdl[1]=no bypass, mdl[2]=zero register
    logic [15:0] mdl [3][8];
    logic [15:0] ms [6];
    logic [31:0] mq [8];
    bit          s_err_m;

    function automatic logic [15:0] exp16(int inst, logic [2:0] sel);
        if (inst == 2 && sel == 3'd0) return 16'h0;
        if (inst != 1 && w && ws == sel) return wd;
        return mdl[inst][sel];
    endfunction

    function automatic logic [15:0] exp_s(logic [2:0] sel);
        if (sel >= 3'd6) return 16'h0;
        if (s_w && s_ws == sel) return s_wd;
        return ms[sel];
    endfunction

    function automatic logic [31:0] exp_q(logic [2:0] sel);
        if (q_w && q_ws == sel) return q_wd;
        return mq[sel];
    endfunction

    function automatic logic [31:0] rd_of(int inst);
        if (inst == 0) return d_rd;
        if (inst == 1) return n_rd;
        return z_rd;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) for (int j = 0; j < 8; j++) mdl[i][j] = 16'h0;
        for (int j = 0; j < 6; j++) ms[j] = 16'h0;
        for (int j = 0; j < 8; j++) mq[j] = 32'h0;
        s_err_m = 1'b0;
    endtask

    // apply this cycle's writes to the model, then advance past the edge
    task automatic step();
        for (int inst = 0; inst < 3; inst++) begin
            if (w && !(inst == 2 && ws == 3'd0)) mdl[inst][ws] = wd;
        end
        if (s_w && s_ws < 3'd6) ms[s_ws] = s_wd;
        if ((s_w && s_ws >= 3'd6) || s_rs[2:0] >= 3'd6 || s_rs[5:3] >= 3'd6) s_err_m = 1'b1;
        if (q_w) mq[q_ws] = q_wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w = 1'b0; ws = '0; wd = '0; rs = '0;
        s_w = 1'b0; s_ws = '0; s_wd = '0; s_rs = '0;
        q_w = 1'b0; q_ws = '0; q_wd = '0; q_rs = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        clear_model();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int sel = 0; sel < 8; sel++) begin
            rs   = {3'(7 - sel), 3'(sel)};
            s_rs = {3'(7 - sel), 3'(sel)};
            q_rs = {4{3'(sel)}};
            #1;
            n_tests++;
            if (d_rd !== 32'h0 || n_rd !== 32'h0 || z_rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read sel=%0d: got %h/%h/%h required 0", sel, d_rd, n_rd, z_rd);
            end
            n_tests++;
            if (s_rd !== 32'h0 || q_rd !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_read_cfg sel=%0d: got %h/%h required 0", sel, s_rd, q_rd);
            end
        end
        idle_inputs();
        n_tests++;
        if ({d_err, n_err, z_err, s_err, q_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b required 00000", {d_err, n_err, z_err, s_err, q_err});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        w = 1'b1; ws = 3'd3; wd = 16'hBEEF; rs = {3'd0, 3'd3};
        #1;
        n_tests++;
        if (d_rd[15:0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h required beef", d_rd[15:0]);
        end
        step();
        w = 1'b0; rs = {3'd3, 3'd0};
        #1;
        n_tests++;
        if (d_rd[31:16] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h required beef", d_rd[31:16]);
        end
    endtask

    task automatic test_no_bypass();
        w = 1'b1; ws = 3'd5; wd = 16'h1234; rs = {3'd5, 3'd5};
        #1;
        n_tests++;
        if (n_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL nobypass_same_cycle: got %h required 00000000", n_rd);
        end
        step();
        w = 1'b0;
        #1;
        n_tests++;
        if (n_rd !== 32'h1234_1234) begin
            n_fail++;
            $display("FAIL nobypass_next_cycle: got %h required 12341234", n_rd);
        end
    endtask

    task automatic test_zero_reg();
        w = 1'b1; ws = 3'd0; wd = 16'hFFFF; rs = {3'd0, 3'd0};
        #1;
        n_tests++;
        if (z_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_reg_bypass: got %h required 00000000", z_rd);
        end
        step();
        w = 1'b0; rs = {3'd1, 3'd0};
        #1;
        n_tests++;
        if (z_rd[15:0] !== 16'h0 || z_rd[31:16] !== mdl[2][1]) begin
            n_fail++;
            $display("FAIL zero_reg_read: got %h required %h0000", z_rd, mdl[2][1]);
        end
        n_tests++;
        if (d_rd[15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL plain_r0_write: got %h required ffff", d_rd[15:0]);
        end
        n_tests++;
        if (z_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg_err: got %b required 0", z_err);
        end
    endtask

    task automatic test_out_of_range();
        s_w = 1'b1; s_ws = 3'd7; s_wd = 16'hAAAA; s_rs = {3'd2, 3'd7};
        #1;
        n_tests++;
        if (s_rd[15:0] !== 16'h0 || s_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_same_cycle: got rd=%h err=%b required 0000/0", s_rd[15:0], s_err);
        end
        step();
        s_w = 1'b0; s_rs = '0;
        n_tests++;
        if (s_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_err_rise: got %b required 1", s_err);
        end
        for (int i = 0; i < 5; i++) begin
            s_rs = {3'(i), 3'(i + 1)};
            #1;
            n_tests++;
            if (s_rd[15:0] !== exp_s(3'(i + 1)) || s_rd[31:16] !== exp_s(3'(i))) begin
                n_fail++;
                $display("FAIL oob_no_change i=%0d: got %h required %h%h", i, s_rd, exp_s(3'(i)), exp_s(3'(i + 1)));
            end
            step();
            n_tests++;
            if (s_err !== 1'b1) begin
                n_fail++;
                $display("FAIL oob_err_sticky i=%0d: got %b required 1", i, s_err);
            end
        end
        s_w = 1'b1; s_ws = 3'd5; s_wd = 16'h7777; s_rs = '0;
        step();
        s_w = 1'b0; s_rs = {3'd5, 3'd5};
        #1;
        n_tests++;
        if (s_rd !== 32'h7777_7777) begin
            n_fail++;
            $display("FAIL oob_write_while_err: got %h required 77777777", s_rd);
        end
        s_rs = '0;
    endtask

    task automatic test_wide_ports();
        q_w = 1'b1; q_ws = 3'd6; q_wd = 32'hDEAD_BEEF; q_rs = '0;
        step();
        q_w = 1'b0; q_rs = {4{3'd6}};
        #1;
        n_tests++;
        if (q_rd !== {4{32'hDEAD_BEEF}}) begin
            n_fail++;
            $display("FAIL wide_same_reg: got %h required 4x deadbeef", q_rd);
        end
        for (int it = 0; it < 20; it++) begin
            logic [2:0] sel [4];
            logic [127:0] r;
            q_w = 1'($urandom_range(0, 1));
            q_ws = 3'($urandom_range(0, 7));
            q_wd = $urandom;
            for (int p = 0; p < 4; p++) begin
                sel[p] = ($urandom_range(0, 1) == 1) ? q_ws : 3'($urandom_range(0, 7));
                q_rs[p*3 +: 3] = sel[p];
            end
            #1;
            r = q_rd;
            for (int p = 0; p < 4; p++) begin
                n_tests++;
                if (r[p*32 +: 32] !== exp_q(sel[p])) begin
                    n_fail++;
                    $display("FAIL wide_random it=%0d port=%0d: got %h required %h", it, p, r[p*32 +: 32], exp_q(sel[p]));
                end
            end
            step();
        end
        q_w = 1'b0; q_rs = '0;
        n_tests++;
        if (q_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_err: got %b required 0", q_err);
        end
    endtask

    task automatic test_random_shared();
        for (int it = 0; it < 40; it++) begin
            w  = 1'($urandom_range(0, 1));
            ws = 3'($urandom_range(0, 7));
            wd = 16'($urandom);
            rs[2:0] = ($urandom_range(0, 1) == 1) ? ws : 3'($urandom_range(0, 7));
            rs[5:3] = 3'($urandom_range(0, 7));
            #1;
            for (int inst = 0; inst < 3; inst++) begin
                logic [31:0] r;
                r = rd_of(inst);
                for (int p = 0; p < 2; p++) begin
                    n_tests++;
                    if (r[p*16 +: 16] !== exp16(inst, rs[p*3 +: 3])) begin
                        n_fail++;
                        $display("FAIL random it=%0d inst=%0d port=%0d: got %h required %h",
                                 it, inst, p, r[p*16 +: 16], exp16(inst, rs[p*3 +: 3]));
                    end
                end
            end
            step();
        end
        w = 1'b0;
        n_tests++;
        if ({d_err, n_err, z_err} !== 3'b0) begin
            n_fail++;
            $display("FAIL random_err: got %b required 000", {d_err, n_err, z_err});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            w = 1'b1; ws = 3'(i); wd = 16'(16'h1111 * i);
            step();
        end
        w = 1'b0; rs = {3'd7, 3'd6};
        #1;
        n_tests++;
        if (d_rd !== 32'h7777_6666) begin
            n_fail++;
            $display("FAIL fill_check: got %h required 77776666", d_rd);
        end
        rst = 1'b0;
        for (int sel = 0; sel < 4; sel++) begin
            rs = {3'(sel + 4), 3'(sel)};
            #1;
            n_tests++;
            if (d_rd !== 32'h0 || n_rd !== 32'h0 || z_rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_mid_read sel=%0d: got %h/%h/%h required 0", sel, d_rd, n_rd, z_rd);
            end
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({d_err, n_err, z_err, s_err, q_err} !== 5'b0 || q_rd !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mid_err: got err=%b q=%h required 00000/0",
                     {d_err, n_err, z_err, s_err, q_err}, q_rd);
        end
        clear_model();
        w = 1'b1; ws = 3'd2; wd = 16'h0042; rs = '0;
        step();
        w = 1'b0; rs = {3'd2, 3'd2};
        #1;
        n_tests++;
        if (d_rd !== 32'h0042_0042 || n_rd !== 32'h0042_0042 || z_rd !== 32'h0042_0042) begin
            n_fail++;
            $display("FAIL reset_mid_write: got %h/%h/%h required 00420042", d_rd, n_rd, z_rd);
        end
        n_tests++;
        if (s_err !== s_err_m) begin
            n_fail++;
            $display("FAIL reset_mid_s_err: got %b required %b", s_err, s_err_m);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_no_bypass();
        test_zero_reg();
        test_out_of_range();
        test_wide_ports();
        test_random_shared();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_param.md
# rf_param

Parametrised successor to the 8x16 two-read-port register file, used by the decode stage of the pipelined core. Adds configurable width, depth and read-port count, optional hard-wired zero register, optional write-to-read bypass, and a registered sticky error flag for illegal register selects. All storage is flip-flop based, written on the rising clock edge and read combinationally.

## Interface
Parameters:
- WIDTH, 16, data width of every register
- DEPTH, 8, number of registers (2..64, need not be a power of two)
- NREAD, 2, number of independent read ports (1..4)
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read of the register being written this cycle returns writedata
- AW (local), max(1, clog2(DEPTH)), select width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- readregsel  in  NREAD*AW  read selects; port k uses bits [k*AW +: AW]
- readdata  out  NREAD*WIDTH  read data; port k on bits [k*WIDTH +: WIDTH]
- write  in  1  write enable
- writeregsel  in  AW  write select
- writedata  in  WIDTH  write data
- err  out  1  sticky error flag, registered

## Operation
- Reset (rst low, asynchronous): all registers clear to 0, err clears to 0. readdata therefore reads 0 for every legal select during and after reset.
- Write: on rising clk with write=1 and writeregsel < DEPTH, register[writeregsel] <= writedata. Suppressed when ZERO_REG=1 and writeregsel=0.
- Read port k, priority order:
  - readregsel_k >= DEPTH -> 0
  - ZERO_REG=1 and readregsel_k = 0 -> 0
  - BYPASS=1, write=1, writeregsel = readregsel_k, writeregsel < DEPTH -> writedata (same cycle)
  - otherwise register[readregsel_k]
- Multiple read ports may select the same register; all return identical data.
- Error event (combinational, per cycle): write=1 with writeregsel >= DEPTH, or any readregsel_k >= DEPTH, or any select bit X/Z under simulation. Out-of-range write is discarded, no register changes.
- err: set on the rising edge following a cycle with an error event, held until rst. Writes and reads continue to operate normally while err=1.
- Power-of-two DEPTH: out-of-range selects are impossible; err stays 0 except on X selects.

## Timing
- Read latency 0 cycles (combinational from readregsel and register contents).
- Write visible on non-bypassed read the cycle after the write edge; with BYPASS=1, visible in the same cycle.
- err latency: 1 cycle after the offending cycle.
- Back-to-back writes to the same register: last write wins; each is visible per above rules.
- Reset asserted mid-write: reset wins, register reads 0; first write accepted on the first rising edge with rst high.
- No handshake; write is accepted every cycle it is asserted.

## Structure
- Shared package rf_pkg: clog2 function, AW derivation helper, RF_MAX_DEPTH=64, RF_MAX_NREAD=4 constants.
- One sub-module: rf_reg — single WIDTH-bit register with write enable and async active-low clear; instantiated DEPTH times via generate (index 0 omitted when ZERO_REG=1).
- Read muxes generated per port from the register array; no separate mux module.
- Elaboration-time check: DEPTH or NREAD outside range is a fatal error.

## Test plan
- Defaults (16x8, 2 ports, BYPASS=1): write 0xBEEF to r3, same cycle read r3 on port0 -> 0xBEEF immediately; port1 reads r3 next cycle -> 0xBEEF.
- BYPASS=0: write 0x1234 to r5 while reading r5 (prior 0) -> 0x0000 that cycle, 0x1234 next cycle.
- ZERO_REG=1: write 0xFFFF to r0 -> r0 reads 0x0000 on all ports; r1 unaffected; err stays 0.
- DEPTH=6, AW=3: write 0xAAAA to select 7 -> no register changes, readdata on select 7 is 0, err rises next edge and stays high through 5 further clean cycles.
- Reset mid-operation: fill r0..r7 with 0x1111*i, pulse rst low for half a cycle between edges -> all reads 0 immediately, err 0; write r2=0x0042 after release -> reads 0x0042.
- NREAD=4, WIDTH=32: all four ports select r6 after writing 0xDEADBEEF -> four identical 0xDEADBEEF outputs.
